// File: rtl/ahb2apb_bridge_param.sv
// AHB-Lite to APB bridge for NUM_SLV equal-size slave windows.
// Handles write data-phase wait, slave errors, decode misses and an ACCESS timeout.
module ahb2apb_bridge_param #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                NUM_SLV   = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                WIN_LOG2  = 26,
    parameter int                TIMEOUT   = 16
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    input  logic [1:0]         Htrans,
    input  logic               Hwrite,
    input  logic               Hreadyin,
    input  logic [ADDR_W-1:0]  Haddr,
    input  logic [DATA_W-1:0]  Hwdata,
    output logic [DATA_W-1:0]  Hrdata,
    output logic               Hreadyout,
    output logic [1:0]         Hresp,
    output logic [NUM_SLV-1:0] Pselx,
    output logic               Penable,
    output logic               Pwrite,
    output logic [ADDR_W-1:0]  Paddr,
    output logic [DATA_W-1:0]  Pwdata,
    input  logic [DATA_W-1:0]  Prdata,
    input  logic               Pready,
    input  logic               Pslverr
);

    localparam int IDX_W = ADDR_W - WIN_LOG2;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t              r_state, w_next, w_req_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [NUM_SLV-1:0]  r_sel;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_valid, w_hit, w_done, w_take, w_tmo;
    logic [IDX_W-1:0]    w_idx;
    logic [NUM_SLV-1:0]  w_sel;

    // NONSEQ or SEQ only; IDLE/BUSY never start a transfer
    assign w_valid = Hreadyin && (Htrans == 2'b10 || Htrans == 2'b11);

    // Subtract-then-shift avoids overflow if the top window touches 2^ADDR_W
    assign w_idx = IDX_W'((Haddr - BASE_ADDR) >> WIN_LOG2);
    assign w_hit = (Haddr >= BASE_ADDR) && (w_idx < IDX_W'(NUM_SLV));

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NUM_SLV; k++)
            w_sel[k] = w_hit && (w_idx == IDX_W'(k));
    end

    assign w_done = (r_state == ACCESS && Pready && !Pslverr) || (r_state == ERR2);
    assign w_take = w_valid && (r_state == IDLE || w_done);
    assign w_tmo  = (TIMEOUT > 0) && (r_state == ACCESS) && !Pready &&
                    (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_req_state = ERR1;
        if (w_hit)
            w_req_state = Hwrite ? WWAIT : SETUP;
    end

    always_comb begin
        w_next    = r_state;
        Hreadyout = 1'b1;
        Hresp     = 2'b00;
        case (r_state)
            IDLE:    if (w_take) w_next = w_req_state;
            WWAIT: begin
                Hreadyout = 1'b0;
                w_next    = SETUP;
            end
            SETUP: begin
                Hreadyout = 1'b0;
                w_next    = ACCESS;
            end
            ACCESS: begin
                Hreadyout = 1'b0;
                if (Pready) begin
                    if (Pslverr) begin
                        w_next = ERR1;
                    end else begin
                        Hreadyout = 1'b1;
                        w_next    = w_take ? w_req_state : IDLE;
                    end
                end else if (w_tmo) begin
                    w_next = ERR1;
                end
            end
            ERR1: begin
                Hreadyout = 1'b0;
                Hresp     = 2'b01;
                w_next    = ERR2;
            end
            ERR2: begin
                Hresp  = 2'b01;
                w_next = w_take ? w_req_state : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            // Misses leave the APB-side registers untouched
            if (w_take && w_hit) begin
                r_addr  <= Haddr;
                r_write <= Hwrite;
                r_sel   <= w_sel;
            end
            if (r_state == WWAIT)
                r_wdata <= Hwdata;
            if (r_state == SETUP)
                r_cnt <= '0;
            else if (r_state == ACCESS && !Pready)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign Pselx   = (r_state == SETUP || r_state == ACCESS) ? r_sel : '0;
    assign Penable = (r_state == ACCESS);
    assign Pwrite  = r_write;
    assign Paddr   = r_addr;
    assign Pwdata  = r_wdata;
    assign Hrdata  = Prdata;

endmodule

// File: tb/tb_ahb2apb_bridge_param.sv
// Directed bench for ahb2apb_bridge_param; APB completions are checked against a scoreboard queue.
module tb_ahb2apb_bridge_param;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic [1:0]  Htrans;
    logic        Hwrite, Hreadyin;
    logic [31:0] Haddr, Hwdata, Hrdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [2:0]  Pselx;
    logic        Penable, Pwrite;
    logic [31:0] Paddr, Pwdata, Prdata;
    logic        Pready, Pslverr;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  sel;
    } exp_t;
    exp_t sb[$];

    ahb2apb_bridge_param dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .Htrans(Htrans), .Hwrite(Hwrite),
        .Hreadyin(Hreadyin), .Haddr(Haddr), .Hwdata(Hwdata), .Hrdata(Hrdata),
        .Hreadyout(Hreadyout), .Hresp(Hresp), .Pselx(Pselx), .Penable(Penable),
        .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(Prdata),
        .Pready(Pready), .Pslverr(Pslverr)
    );

    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic wr, input logic [31:0] a);
        Htrans = 2'b10;
        Hwrite = wr;
        Haddr  = a;
    endtask

    task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        exp_t e;
        e.wr = wr; e.addr = a; e.wdata = d; e.sel = s;
        sb.push_back(e);
    endtask

    // APB completion monitor
    always @(negedge Hclk) begin
        exp_t e;
        #1;
        if (Hresetn && Penable && Pready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL sb_empty: observed APB completion at %0h expected none", Paddr);
            end else begin
                e = sb.pop_front();
                chk("sb_pwrite", 32'(Pwrite), 32'(e.wr));
                chk("sb_paddr", Paddr, e.addr);
                chk("sb_psel", 32'(Pselx), 32'(e.sel));
                if (e.wr) chk("sb_pwdata", Pwdata, e.wdata);
                else      chk("sb_hrdata", Hrdata, Prdata);
            end
        end
    end

    initial begin
        Hresetn = 1'b0; Htrans = 2'b00; Hwrite = 1'b0; Hreadyin = 1'b1;
        Haddr = '0; Hwdata = '0; Prdata = '0; Pready = 1'b1; Pslverr = 1'b0;
        repeat (2) @(negedge Hclk);
        #1;
        chk("rst_hready", 32'(Hreadyout), 1);
        chk("rst_hresp", 32'(Hresp), 0);
        chk("rst_psel", 32'(Pselx), 0);
        chk("rst_penable", 32'(Penable), 0);
        chk("rst_paddr", Paddr, 0);
        chk("rst_pwdata", Pwdata, 0);
        chk("rst_pwrite", 32'(Pwrite), 0);
        @(negedge Hclk); Hresetn = 1'b1;

        // BUSY and not-ready NONSEQ are ignored
        @(negedge Hclk); Htrans = 2'b01; Haddr = 32'h8000_0000;
        @(negedge Hclk); Htrans = 2'b10; Hreadyin = 1'b0;
        @(negedge Hclk); Htrans = 2'b00; Hreadyin = 1'b1;
        #1; chk("ign_psel", 32'(Pselx), 0); chk("ign_hready", 32'(Hreadyout), 1);

        // Read to slave 1
        @(negedge Hclk); req(1'b0, 32'h8400_0010); Prdata = 32'h1234_5678;
        push(1'b0, 32'h8400_0010, 32'h0, 3'b010);
        #1; chk("rd_idle_hready", 32'(Hreadyout), 1);
        @(negedge Hclk); Htrans = 2'b00;
        #1; chk("rd_setup_psel", 32'(Pselx), 32'h2); chk("rd_setup_pen", 32'(Penable), 0);
        chk("rd_setup_hready", 32'(Hreadyout), 0); chk("rd_setup_paddr", Paddr, 32'h8400_0010);
        @(negedge Hclk);
        #1; chk("rd_acc_pen", 32'(Penable), 1); chk("rd_acc_hready", 32'(Hreadyout), 1);
        chk("rd_hrdata", Hrdata, 32'h1234_5678); chk("rd_hresp", 32'(Hresp), 0);
        @(negedge Hclk);
        #1; chk("rd_done_psel", 32'(Pselx), 0);

        // Write to slave 0, then back-to-back read of slave 2 with 3 wait states
        req(1'b1, 32'h8000_0004);
        push(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 3'b001);
        @(negedge Hclk); Htrans = 2'b00; Hwdata = 32'hDEAD_BEEF;
        #1; chk("wr_wwait_psel", 32'(Pselx), 0); chk("wr_wwait_hready", 32'(Hreadyout), 0);
        @(negedge Hclk); Hwdata = 32'h5555_5555;
        #1; chk("wr_setup_psel", 32'(Pselx), 32'h1); chk("wr_setup_pen", 32'(Penable), 0);
        chk("wr_setup_pwrite", 32'(Pwrite), 1);
        @(negedge Hclk); req(1'b0, 32'h8800_0020); Prdata = 32'hCAFE_0001;
        push(1'b0, 32'h8800_0020, 32'h0, 3'b100);
        #1; chk("wr_acc_pen", 32'(Penable), 1); chk("wr_acc_pwdata", Pwdata, 32'hDEAD_BEEF);
        chk("wr_acc_hready", 32'(Hreadyout), 1);
        @(negedge Hclk); Htrans = 2'b00; Pready = 1'b0;
        #1; chk("b2b_psel", 32'(Pselx), 32'h4); chk("b2b_pwrite", 32'(Pwrite), 0);
        chk("b2b_paddr", Paddr, 32'h8800_0020); chk("b2b_pen", 32'(Penable), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Hclk);
            #1; chk("ws_hready", 32'(Hreadyout), 0); chk("ws_pen", 32'(Penable), 1);
            chk("ws_paddr", Paddr, 32'h8800_0020);
        end
        @(negedge Hclk); Pready = 1'b1;
        #1; chk("ws_done_hready", 32'(Hreadyout), 1);

        // Slave error on slave 0 read
        @(negedge Hclk); req(1'b0, 32'h8000_0100); Prdata = 32'h0BAD_F00D;
        push(1'b0, 32'h8000_0100, 32'h0, 3'b001);
        @(negedge Hclk); Htrans = 2'b00;
        @(negedge Hclk); Pslverr = 1'b1;
        #1; chk("se_acc_hready", 32'(Hreadyout), 0);
        @(negedge Hclk); Pslverr = 1'b0;
        #1; chk("se_err1_hresp", 32'(Hresp), 1); chk("se_err1_hready", 32'(Hreadyout), 0);
        chk("se_err1_psel", 32'(Pselx), 0);
        @(negedge Hclk);
        #1; chk("se_err2_hresp", 32'(Hresp), 1); chk("se_err2_hready", 32'(Hreadyout), 1);

        // Write decode miss: APB untouched, then top-of-window hit straight from ERR2
        @(negedge Hclk); req(1'b1, 32'h9000_0000);
        @(negedge Hclk); Htrans = 2'b00; Hwdata = 32'h0BAD_0BAD;
        #1; chk("miss_err1_hresp", 32'(Hresp), 1); chk("miss_err1_hready", 32'(Hreadyout), 0);
        chk("miss_err1_psel", 32'(Pselx), 0);
        @(negedge Hclk); req(1'b0, 32'h8BFF_FFFC); Prdata = 32'h7777_0002;
        push(1'b0, 32'h8BFF_FFFC, 32'h0, 3'b100);
        #1; chk("miss_err2_hresp", 32'(Hresp), 1); chk("miss_err2_hready", 32'(Hreadyout), 1);
        chk("miss_err2_psel", 32'(Pselx), 0);
        @(negedge Hclk); Htrans = 2'b00;
        #1; chk("top_setup_psel", 32'(Pselx), 32'h4); chk("top_setup_paddr", Paddr, 32'h8BFF_FFFC);
        chk("miss_pwdata", Pwdata, 32'hDEAD_BEEF);
        @(negedge Hclk); req(1'b0, 32'h7FFF_FFFC);
        @(negedge Hclk); Htrans = 2'b00;
        #1; chk("low_err1_hresp", 32'(Hresp), 1); chk("low_err1_psel", 32'(Pselx), 0);
        chk("low_paddr", Paddr, 32'h8BFF_FFFC);
        @(negedge Hclk); req(1'b0, 32'h8C00_0000);
        @(negedge Hclk); Htrans = 2'b00;
        #1; chk("hi_err1_hresp", 32'(Hresp), 1); chk("hi_err1_psel", 32'(Pselx), 0);
        @(negedge Hclk);
        @(negedge Hclk);
        #1; chk("hi_idle_hready", 32'(Hreadyout), 1); chk("hi_idle_hresp", 32'(Hresp), 0);

        // Timeout: 16 unanswered ACCESS cycles
        req(1'b0, 32'h8400_0000);
        @(negedge Hclk); Htrans = 2'b00; Pready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge Hclk);
            #1; chk("to_acc_pen", 32'(Penable), 1); chk("to_acc_hready", 32'(Hreadyout), 0);
        end
        @(negedge Hclk);
        #1; chk("to_err1_pen", 32'(Penable), 0); chk("to_err1_psel", 32'(Pselx), 0);
        chk("to_err1_hresp", 32'(Hresp), 1); chk("to_err1_hready", 32'(Hreadyout), 0);
        @(negedge Hclk); Pready = 1'b1;
        #1; chk("to_err2_hready", 32'(Hreadyout), 1); chk("to_err2_hresp", 32'(Hresp), 1);

        // Reset in the middle of a transfer
        @(negedge Hclk); req(1'b0, 32'h8000_0008);
        @(negedge Hclk); Htrans = 2'b00; Hresetn = 1'b0;
        #1; chk("mid_rst_psel", 32'(Pselx), 0); chk("mid_rst_paddr", Paddr, 0);
        chk("mid_rst_hready", 32'(Hreadyout), 1); chk("mid_rst_pen", 32'(Penable), 0);
        @(negedge Hclk); Hresetn = 1'b1;
        @(negedge Hclk); req(1'b0, 32'h8000_000C); Prdata = 32'h4242_4242;
        push(1'b0, 32'h8000_000C, 32'h0, 3'b001);
        @(negedge Hclk); Htrans = 2'b00;
        #1; chk("post_rst_psel", 32'(Pselx), 32'h1); chk("post_rst_paddr", Paddr, 32'h8000_000C);
        @(negedge Hclk);
        #1; chk("post_rst_pen", 32'(Penable), 1);
        @(negedge Hclk);
        #1; chk("sb_drain", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb2apb_bridge_param.md
AHB2APB_BRIDGE_PARAM -- requirements
Module: ahb2apb_bridge_param

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter NUM_SLV, default 3, APB slave count, legal range 1..8.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h8000_0000, base of slave 0 window.
REQ-005 SHALL have parameter WIN_LOG2, default 26, log2 of window size in bytes; slave k owns [BASE_ADDR+k*2^WIN_LOG2, BASE_ADDR+(k+1)*2^WIN_LOG2).
REQ-006 SHALL have parameter TIMEOUT, default 16, max ACCESS cycles; 0 disables timeout.
REQ-007 SHALL have one clock and an asynchronous, active-low reset: Hclk input 1 (clock), Hresetn input 1 (reset).
REQ-008 SHALL have the following AHB-side ports:
- Htrans in 2
- Hwrite in 1
- Hreadyin in 1
- Haddr in ADDR_W
- Hwdata in DATA_W
- Hrdata out DATA_W
- Hreadyout out 1
- Hresp out 2 (00 OKAY, 01 ERROR)
REQ-009 SHALL have the following APB-side ports:
- Pselx out NUM_SLV (one-hot)
- Penable out 1
- Pwrite out 1
- Paddr out ADDR_W
- Pwdata out DATA_W
- Prdata in DATA_W (pre-muxed)
- Pready in 1
- Pslverr in 1

Function
REQ-010 SHALL treat a valid transfer as Hreadyin=1 and Htrans[1]=1 sampled at a rising Hclk (address phase, cycle T).
REQ-011 SHALL use FSM states IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2.
REQ-012 SHALL latch Haddr and Hwrite at T.
- Decoded read: IDLE->SETUP at T+1.
- Decoded write: IDLE->WWAIT at T+1, capturing Hwdata into Pwdata at T+1, then SETUP at T+2.
REQ-013 SHALL drive SETUP as: Pselx one-hot for the decoded slave, Penable=0, Paddr/Pwrite from the latch; SETUP->ACCESS unconditionally.
REQ-014 SHALL drive ACCESS as: Pselx held, Penable=1; Paddr, Pwrite and Pwdata SHALL remain stable until exit.
REQ-015 SHALL stay in ACCESS while Pready=0, with Hreadyout=0.
REQ-016 SHALL complete ACCESS when Pready=1 and Pslverr=0: Hreadyout=1, Hresp=00.
REQ-017 SHALL route ACCESS with Pready=1 and Pslverr=1 to ERR1, with Hreadyout=0.
REQ-018 SHALL route a valid transfer whose Haddr lies outside all NUM_SLV windows to ERR1 at T+1 with no Pselx assertion; a write to such an address SHALL NOT touch APB.
REQ-019 SHALL drive the two-cycle ERROR response as: ERR1 Hresp=01, Hreadyout=0; ERR2 Hresp=01, Hreadyout=1.
REQ-020 SHALL, in a completing cycle (ACCESS with Pready=1 and Pslverr=0, or ERR2), sample any new valid transfer as its address phase and enter SETUP, WWAIT or ERR1 directly, else IDLE; no idle bubble.
REQ-021 SHALL drive Hreadyout=0 in WWAIT and SETUP, and Hreadyout=1 in IDLE.
REQ-022 SHALL drive Hrdata = Prdata combinationally; Hrdata SHALL equal Prdata whenever Penable=1.
REQ-023 SHALL, when TIMEOUT>0, count ACCESS cycles with Pready=0; when the count reaches TIMEOUT, it SHALL drop Pselx/Penable and go to ERR1; the counter SHALL clear on ACCESS entry.
REQ-024 SHALL keep Pselx $onehot0 at all times, and SHALL never hold Penable=1 for two consecutive cycles of separate transfers.
REQ-025 SHALL ignore Htrans IDLE/BUSY (Htrans[1]=0) in IDLE and in completing cycles.

Reset
REQ-026 SHALL, on Hresetn=0 asynchronously:
- state=IDLE
- Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0
- Hreadyout=1, Hresp=00
- timeout counter=0
REQ-027 SHALL, on reset mid-transfer, abandon the transfer; the first valid transfer after deassertion SHALL start from IDLE timing.

Verification
REQ-028 Read: read of Haddr=0x8400_0010 with Pready=1 -> Pselx=3'b010 at T+1, Penable=1 and Hreadyout=1 at T+2, Hrdata=Prdata=0x1234_5678.
REQ-029 Write: write of Haddr=0x8000_0004 with Hwdata=0xDEAD_BEEF -> Pselx=3'b001 at T+2, Penable=1 at T+3, Pwdata=0xDEAD_BEEF, Pwrite=1.
REQ-030 Wait states and slave error:
- Pready held 0 for 3 ACCESS cycles -> Hreadyout=0 for 3 extra cycles, Paddr stable throughout.
- Pslverr=1 -> ERR1 then ERR2, Hresp=01/01, Hreadyout=0/1.
REQ-031 Decode miss: access to Haddr=0x9000_0000 -> Pselx=0 throughout, Hresp=01 for two cycles, Hreadyout 0 then 1.
REQ-032 Timeout: Pready=0 for 16 ACCESS cycles -> Penable=0 and ERR1 on the 17th cycle.
REQ-033 Back-to-back: a write followed by a read presented in the completing cycle -> read SETUP on the next cycle, Pwrite=0, Paddr = read address.
